// File: rtl/noc_flit_sink.sv
// noc_flit_sink: terminal NoC sink. It accepts flits addressed to (SINK_X, SINK_Y),
// queues their 16-bit payloads in a small receive FIFO for a downstream consumer,
// throws away misrouted flits and keeps saturating telemetry counters.
//
// Optional feature: define FLIT_SINK_SEQCHECK_EN to build the payload sequence
// checker that drives seq_err_count. Without that macro, seq_err_count is tied to
// zero and no tracker logic is built.
//
// Flit fields: dx=[55:48], dy=[47:40], flags=[39:38], payload=[37:22].
module noc_flit_sink #(
   parameter int FLIT_WIDTH = 64,
   parameter int SINK_X     = 0,
   parameter int SINK_Y     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  halt_on_err,
   input  logic [7:0]            bp_pattern,
   input  logic [FLIT_WIDTH-1:0] flit_in,
   input  logic                  valid_in,
   output logic                  ready_out,
   output logic [15:0]           data_out,
   output logic                  data_valid_out,
   input  logic                  data_ready_in,
   output logic [31:0]           flits_rx_count,
   output logic [31:0]           misroute_count,
   output logic [31:0]           seq_err_count,
   output logic [31:0]           stall_count
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [7:0]       MY_X    = 8'(SINK_X);
   localparam logic [7:0]       MY_Y    = 8'(SINK_Y);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Counters stop at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   state_t            state_q, state_d;
   logic [2:0]        bp_ptr_q, bp_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [15:0]       mem_q [FIFO_DEPTH];
   logic [31:0]       flits_rx_q, flits_rx_d;
   logic [31:0]       misroute_q, misroute_d;
   logic [31:0]       stall_q, stall_d;

   logic              fifo_full;
   logic              xfer;
   logic              dest_match;
   logic              push;
   logic              pop;
   logic [15:0]       payload;
   logic              unused_flit;

   assign payload     = flit_in[37:22];
   assign dest_match  = (flit_in[55:48] == MY_X) && (flit_in[47:40] == MY_Y);
   // Fields the sink never looks at.
   assign unused_flit = ^{flit_in[FLIT_WIDTH-1:56], flit_in[39:38], flit_in[21:0]};

   // Handshake and FIFO control. ready_out comes only from flops so it never
   // loops back through valid_in; a full FIFO blocks input even if it pops now.
   always_comb begin
      fifo_full      = (count_q == DEPTH_C);
      ready_out      = (state_q == ST_RUN) && !fifo_full && !bp_pattern[bp_ptr_q];
      data_valid_out = (count_q != '0);
      data_out       = data_valid_out ? mem_q[rd_ptr_q] : 16'h0000;
      xfer           = valid_in && ready_out && !clear;
      push           = xfer && dest_match;
      pop            = data_valid_out && data_ready_in && !clear;
   end

   // Operating-mode FSM and backpressure slot pointer; clear beats everything.
   always_comb begin
      state_d  = state_q;
      bp_ptr_d = bp_ptr_q;
      case (state_q)
         ST_IDLE: begin
            bp_ptr_d = 3'd0;
            if (enable) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            bp_ptr_d = bp_ptr_q + 3'd1;
            if (xfer && !dest_match && halt_on_err) begin
               state_d = ST_HALT;
            end else if (!enable) begin
               state_d = ST_IDLE;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d  = ST_IDLE;
            bp_ptr_d = 3'd0;
         end
      endcase
      if (clear) begin
         state_d  = ST_IDLE;
         bp_ptr_d = 3'd0;
      end
   end

   // FIFO pointers and occupancy; depth is a power of two so pointers wrap freely.
   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // Telemetry counters; stalls only count while the sink is active (RUN/HALT).
   always_comb begin
      flits_rx_d = sat_inc(flits_rx_q, xfer);
      misroute_d = sat_inc(misroute_q, xfer && !dest_match);
      stall_d    = sat_inc(stall_q, valid_in && !ready_out && (state_q != ST_IDLE));
      if (clear) begin
         flits_rx_d = 32'd0;
         misroute_d = 32'd0;
         stall_d    = 32'd0;
      end
   end

   // Control and counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         bp_ptr_q   <= 3'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         flits_rx_q <= 32'd0;
         misroute_q <= 32'd0;
         stall_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         bp_ptr_q   <= bp_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         flits_rx_q <= flits_rx_d;
         misroute_q <= misroute_d;
         stall_q    <= stall_d;
      end
   end

   // Payload storage; contents are only visible through data_out while occupied,
   // so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= payload;
      end
   end

   assign flits_rx_count = flits_rx_q;
   assign misroute_count = misroute_q;
   assign stall_count    = stall_q;

`ifdef FLIT_SINK_SEQCHECK_EN
   logic        seeded_q, seeded_d;
   logic [15:0] expect_q, expect_d;
   logic [31:0] seq_err_q, seq_err_d;

   // Sequence tracker: every matched payload reseeds the expectation to payload+1;
   // a mismatch only counts once the tracker has been seeded.
   always_comb begin
      seeded_d  = seeded_q;
      expect_d  = expect_q;
      seq_err_d = seq_err_q;
      if (clear) begin
         seeded_d  = 1'b0;
         expect_d  = 16'h0000;
         seq_err_d = 32'd0;
      end else if (push) begin
         seeded_d  = 1'b1;
         expect_d  = payload + 16'd1;
         seq_err_d = sat_inc(seq_err_q, seeded_q && (payload != expect_q));
      end
   end

   // Sequence tracker registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seeded_q  <= 1'b0;
         expect_q  <= 16'h0000;
         seq_err_q <= 32'd0;
      end else begin
         seeded_q  <= seeded_d;
         expect_q  <= expect_d;
         seq_err_q <= seq_err_d;
      end
   end

   assign seq_err_count = seq_err_q;
`else
   assign seq_err_count = 32'd0;
`endif

endmodule

// File: tb/tb_noc_flit_sink.sv
// tb_noc_flit_sink: directed scenarios plus a randomized run, each cycle compared
// against a queue-based reference model of the sink.
module tb_noc_flit_sink;

   localparam int FW    = 64;
   localparam int DEPTH = 4;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_HALT = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b0;
   logic          clear = 1'b0;
   logic          halt_on_err = 1'b0;
   logic [7:0]    bp_pattern = 8'h00;
   logic [FW-1:0] flit_in = '0;
   logic          valid_in = 1'b0;
   logic          data_ready_in = 1'b0;
   logic          ready_out;
   logic [15:0]   data_out;
   logic          data_valid_out;
   logic [31:0]   flits_rx_count, misroute_count, seq_err_count, stall_count;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   int          m_mode = M_IDLE;
   int          m_slot = 0;
   logic [15:0] m_q[$];
   longint      m_rx = 0, m_mis = 0, m_stall = 0, m_seq = 0;
   bit          m_seeded = 1'b0;
   logic [15:0] m_next = 16'h0;
   bit          m_xfer = 1'b0;

   always #5 clk = ~clk;

   noc_flit_sink #(
      .FLIT_WIDTH(FW), .SINK_X(0), .SINK_Y(0), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
      .halt_on_err(halt_on_err), .bp_pattern(bp_pattern), .flit_in(flit_in),
      .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
      .data_valid_out(data_valid_out), .data_ready_in(data_ready_in),
      .flits_rx_count(flits_rx_count), .misroute_count(misroute_count),
      .seq_err_count(seq_err_count), .stall_count(stall_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat32(input longint v);
      return (v > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   function automatic bit model_ready();
      return (m_mode == M_RUN) && (m_q.size() < DEPTH) && (bp_pattern[m_slot] == 1'b0);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_slot = 0; m_q.delete();
      m_rx = 0; m_mis = 0; m_stall = 0; m_seq = 0;
      m_seeded = 1'b0; m_next = 16'h0; m_xfer = 1'b0;
   endtask

   // Advance the model by one rising edge using the inputs currently driven.
   task automatic model_update();
      bit rdy, match;
      logic [15:0] pay;
      rdy   = model_ready();
      match = (flit_in[55:48] == 8'd0) && (flit_in[47:40] == 8'd0);
      pay   = flit_in[37:22];
      m_xfer = 1'b0;
      if (!reset_n || clear) begin
         model_reset();
         return;
      end
      m_xfer = valid_in && rdy;
      if (valid_in && !rdy && m_mode != M_IDLE) m_stall++;
      if (m_q.size() > 0 && data_ready_in) void'(m_q.pop_front());
      if (m_xfer) begin
         m_rx++;
         $display("xfer t=%0t dest=(%0d,%0d) payload=%h %s", $time,
                  flit_in[55:48], flit_in[47:40], pay, match ? "queued" : "misrouted");
         if (match) begin
            m_q.push_back(pay);
            if (m_seeded && pay != m_next) m_seq++;
            m_seeded = 1'b1;
            m_next = pay + 16'd1;
         end else begin
            m_mis++;
         end
      end
      case (m_mode)
         M_IDLE: if (enable) begin m_mode = M_RUN; m_slot = 0; end
         M_RUN: begin
            if (m_xfer && !match && halt_on_err) m_mode = M_HALT;
            else if (!enable) m_mode = M_IDLE;
            else m_slot = (m_slot + 1) % 8;
         end
         default: ;
      endcase
   endtask

   // Compare every output with the model, then take one clock edge.
   task automatic tick();
      logic [31:0] seq_exp;
`ifdef FLIT_SINK_SEQCHECK_EN
      seq_exp = sat32(m_seq);
`else
      seq_exp = 32'd0;
`endif
      #1;
      check_val("ready_out", {31'b0, ready_out}, {31'b0, model_ready()});
      check_val("data_valid_out", {31'b0, data_valid_out}, {31'b0, m_q.size() != 0});
      check_val("data_out", {16'b0, data_out}, {16'b0, (m_q.size() != 0) ? m_q[0] : 16'h0});
      check_val("flits_rx_count", flits_rx_count, sat32(m_rx));
      check_val("misroute_count", misroute_count, sat32(m_mis));
      check_val("stall_count", stall_count, sat32(m_stall));
      check_val("seq_err_count", seq_err_count, seq_exp);
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic set_flit(input logic [7:0] dx, input logic [7:0] dy,
                           input logic [15:0] pay, input logic vld);
      flit_in = {$urandom, $urandom};
      flit_in[55:48] = dx;
      flit_in[47:40] = dy;
      flit_in[37:22] = pay;
      valid_in = vld;
   endtask

   // Clear into IDLE, then one enabled cycle to reach RUN.
   task automatic start_run();
      clear = 1'b1; enable = 1'b1; valid_in = 1'b0;
      tick();
      clear = 1'b0;
      tick();
   endtask

   initial begin
      logic [15:0] s5_pay [4];
      logic [15:0] seq_pay;
      int sent;
      s5_pay[0] = 16'hFFFE; s5_pay[1] = 16'hFFFF; s5_pay[2] = 16'h0000; s5_pay[3] = 16'h0005;

      // Reset state
      @(negedge clk);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Scenario 1: four back-to-back matched flits, consumer always ready
      start_run();
      bp_pattern = 8'h00; data_ready_in = 1'b1; halt_on_err = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_flit(8'd0, 8'd0, 16'(i + 1), 1'b1);
         tick();
         check_val("s1_data_out", {16'b0, data_out}, 32'(i + 1));
      end
      valid_in = 1'b0;
      tick();
      check_val("s1_rx", flits_rx_count, 32'd4);
      check_val("s1_misroute", misroute_count, 32'd0);

      // Scenario 2: consumer stalled until FIFO fills, then drains
      start_run();
      sent = 0;
      for (int c = 0; c < 14; c++) begin
         data_ready_in = (c >= 7);
         set_flit(8'd0, 8'd0, 16'(16'h0010 + sent), sent < 6);
         tick();
         if (m_xfer) sent++;
      end
      valid_in = 1'b0;
      check_val("s2_rx", flits_rx_count, 32'd6);
      check_val("s2_stall", stall_count, 32'd4);
      check_val("s2_empty", {31'b0, data_valid_out}, 32'd0);

      // Scenario 3: misroute with halt enabled, then clear
      start_run();
      halt_on_err = 1'b1;
      set_flit(8'd1, 8'd0, 16'h0abc, 1'b1);
      tick();
      check_val("s3_misroute", misroute_count, 32'd1);
      check_val("s3_halt_ready", {31'b0, ready_out}, 32'd0);
      set_flit(8'd0, 8'd0, 16'h0abd, 1'b1);
      tick();
      check_val("s3_stall", stall_count, 32'd1);
      clear = 1'b1; valid_in = 1'b0;
      tick();
      clear = 1'b0; halt_on_err = 1'b0;
      check_val("s3_clr_rx", flits_rx_count, 32'd0);
      check_val("s3_clr_mis", misroute_count, 32'd0);
      check_val("s3_clr_stall", stall_count, 32'd0);
      check_val("s3_idle_ready", {31'b0, ready_out}, 32'd0);

      // Scenario 4: slot 0 throttled over 16 RUN cycles
      start_run();
      bp_pattern = 8'h01; data_ready_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         set_flit(8'd0, 8'd0, 16'(i), 1'b1);
         tick();
      end
      valid_in = 1'b0;
      check_val("s4_rx", flits_rx_count, 32'd14);
      check_val("s4_stall", stall_count, 32'd2);
      bp_pattern = 8'h00;

      // Scenario 5: sequence wrap through zero then a jump
      start_run();
      for (int i = 0; i < 4; i++) begin
         set_flit(8'd0, 8'd0, s5_pay[i], 1'b1);
         tick();
      end
      valid_in = 1'b0;
      tick();
`ifdef FLIT_SINK_SEQCHECK_EN
      check_val("s5_seq_err", seq_err_count, 32'd1);
`else
      check_val("s5_seq_err", seq_err_count, 32'd0);
`endif

      // Randomized run
      seq_pay = 16'(100);
      for (int c = 0; c < 1500; c++) begin
         if (c % 100 == 0) begin
            bp_pattern  = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            halt_on_err = ($urandom_range(0, 3) == 0);
         end
         enable        = ($urandom_range(0, 19) != 0);
         clear         = ($urandom_range(0, 63) == 0);
         data_ready_in = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 7) == 0)
            set_flit(8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), 16'($urandom),
                     $urandom_range(0, 9) < 7);
         else
            set_flit(8'd0, 8'd0, ($urandom_range(0, 9) == 0) ? 16'($urandom) : seq_pay,
                     $urandom_range(0, 9) < 7);
         tick();
         if (m_xfer) seq_pay = seq_pay + 16'd1;
      end
      clear = 1'b0; halt_on_err = 1'b0; bp_pattern = 8'h00;

      // Scenario 6: asynchronous reset in the middle of a burst
      start_run();
      data_ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_flit(8'd0, 8'd0, 16'(16'h0200 + i), 1'b1);
         tick();
      end
      #2 reset_n = 1'b0;
      #1;
      check_val("s6_ready", {31'b0, ready_out}, 32'd0);
      check_val("s6_dvalid", {31'b0, data_valid_out}, 32'd0);
      check_val("s6_dout", {16'b0, data_out}, 32'd0);
      check_val("s6_rx", flits_rx_count, 32'd0);
      check_val("s6_stall", stall_count, 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      valid_in = 1'b0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
